mips_dmem_responder: RTL and testbench
======================================

Name: mips_dmem_responder

Overview:
- Data-memory responder: the memory side of the load/store request interface driven by mips_32_bit.
- Accepts one request at a time over a valid/ready handshake.
- Inserts a configurable number of wait states, performs a word read or a byte-enabled write, then returns a single-cycle response.
- Used as the CPU's data memory in simulation and in the CPU bench.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; must be a power of 2, at least 2.
- WAIT_STATES, 2, idle cycles between request acceptance and the access; 0 to 15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = in reset).
- req_valid  in  1  initiator presents a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables; bit i covers bits 8i+7:8i.
- req_ready  out  1  responder can accept a request this cycle.
- rsp_valid  out  1  response valid, one-cycle pulse.
- rsp_rdata  out  32  load data.
- rsp_err  out  1  access error (only with the optional feature).

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter 0. Memory contents are not reset.
- Reset mid-operation abandons a pending request. An uncommitted write is never performed.
- State machine: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1, capture write, addr, wdata, be. This is the accept cycle N.
  - If WAIT_STATES>0, go to WAIT with counter=WAIT_STATES-1. Otherwise go to RESP.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - On counter==0, go to RESP.
- Access at entry to RESP (same edge):
  - Read: rsp_rdata = mem[index].
  - Write: bytes with be=1 are updated; other bytes keep their value. rsp_rdata=0.
  - be=4'b0000 on a write is a no-op write that still responds.
- RESP:
  - rsp_valid=1 for exactly one cycle, req_ready=0.
  - Next state is IDLE. In IDLE, rsp_valid=0 and rsp_rdata holds its last value.
- Latency: the rsp_valid cycle is N+WAIT_STATES+1. Back-to-back requests are accepted at most every WAIT_STATES+2 cycles.
- index = req_addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses alias and wrap modulo 4*DEPTH_WORDS bytes.
- Read-after-write to the same word returns the merged data.
- req_* inputs are sampled only on the accept cycle. Changes after acceptance have no effect.

Optional Feature:
- Macro MIPS_DMEM_ALIGN_CHECK_EN.
- Defined:
  - A request with req_addr[1:0]!=2'b00 and be==4'b1111, or with be not in the legal set for its alignment, is an error.
  - Legal be sets: byte = one bit set at position req_addr[1:0]; halfword = 4'b0011 or 4'b1100 with req_addr[0]=0; word = 4'b1111 with req_addr[1:0]=0.
  - On error: the write is suppressed, rsp_rdata=0, and rsp_err=1 alongside rsp_valid. Timing is unchanged.
- Not defined: req_addr[1:0] is ignored, rsp_err is tied to 0, and be is applied as given.

Decomposition:
- Package mips_mem_pkg holds:
  - WORD_W=32 and BE_W=4 constants.
  - State enum dmem_state_t {IDLE, WAIT, RESP}.
  - Captured-request struct dmem_req_t {write, addr, wdata, be}.
  - Function be_legal(addr_lo, be) used by the align check.
- One sub-module, mips_dmem_array: DEPTH_WORDS x 32 storage with byte-enable write and read port, written and read on the RESP-entry edge.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release -> req_ready=1, rsp_valid=0, rsp_rdata=0 on the first cycle after release.
- Store word then load word, WAIT_STATES=2:
  - Store addr 0x10, wdata 0xDEADBEEF, be=1111 accepted at cycle N -> rsp_valid at N+3 with rdata 0.
  - Load addr 0x10 -> rdata 0xDEADBEEF, 3 cycles after its accept.
  - req_ready=0 from N+1 to N+3.
- Partial store: word 0x20 = 0x11223344, then store wdata 0xAABBCCDD with be=0100 -> load 0x20 returns 0x11BB3344.
- Wrap, DEPTH_WORDS=256: store 0x5A5A5A5A to 0x400, then load 0x0 -> 0x5A5A5A5A.
- WAIT_STATES=0: accept at N -> rsp_valid at N+1. A request held valid continuously is accepted every 2 cycles.
- Reset mid-WAIT: store to 0x30 accepted, rst=0 one cycle later. After release, a load of 0x30 returns the prior contents, not the store data.
- With MIPS_DMEM_ALIGN_CHECK_EN: store addr 0x31, be=1111 -> rsp_err=1 with rsp_valid, rdata 0, word 0x30 unchanged.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types for the data-memory responder: widths, FSM states, the
// captured-request record and the alignment legality check used when
// MIPS_DMEM_ALIGN_CHECK_EN is defined.
package mips_mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic              write;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } dmem_req_t;

  // Byte: single lane matching addr_lo. Halfword: either half with an even
  // addr_lo. Word: all lanes at addr_lo 0. Everything else is illegal.
  function automatic logic be_legal(input logic [1:0] addr_lo, input logic [BE_W-1:0] be);
    logic ok;
    ok = 1'b0;
    case (be)
      4'b0001: ok = (addr_lo == 2'd0);
      4'b0010: ok = (addr_lo == 2'd1);
      4'b0100: ok = (addr_lo == 2'd2);
      4'b1000: ok = (addr_lo == 2'd3);
      4'b0011,
      4'b1100: ok = ~addr_lo[0];
      4'b1111: ok = (addr_lo == 2'd0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mips_dmem_array.sv
// Word-organised storage with per-byte write enables and an asynchronous
// read port. The responder samples the read data on the same edge that it
// would write, so a single access per request is all that is ever needed.
module mips_dmem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Byte-lane write: only enabled lanes change, the rest keep their value.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the mips_32_bit load/store port.
// Optional build macro: MIPS_DMEM_ALIGN_CHECK_EN enables the alignment /
// byte-enable legality check and drives rsp_err; without it rsp_err is 0
// and the low address bits are ignored.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_ready is 1 only in IDLE. The response is a
// single-cycle rsp_valid pulse with no back-pressure; rsp_rdata holds its
// value afterwards until the next response.
module mips_dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output dmem_state_t       dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  dmem_state_t       state_q, state_d;
  dmem_req_t         req_q, req_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  dmem_req_t         live_req;
  dmem_req_t         acc_req;
  logic              access;
  logic              acc_err;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;

  assign live_req = '{write: req_write, addr: req_addr, wdata: req_wdata, be: req_be};

  // With zero wait states the access happens on the accept edge itself, so
  // the live inputs are used there; otherwise the captured copy is used.
  assign acc_req = (state_q == IDLE) ? live_req : req_q;

`ifdef MIPS_DMEM_ALIGN_CHECK_EN
  logic unused_addr_hi;
  assign unused_addr_hi = ^acc_req.addr[WORD_W-1:AW+2];
  assign acc_err        = ~be_legal(acc_req.addr[1:0], acc_req.be);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{acc_req.addr[WORD_W-1:AW+2], acc_req.addr[1:0]};
  assign acc_err          = 1'b0;
`endif

  // Next-state logic: accept in IDLE, count down in WAIT, one RESP cycle.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d = live_req;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RESP;
            access  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response data/error: loaded on the RESP-entry edge, error lasts one cycle.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = 1'b0;
    if (access) begin
      rdata_d = (acc_req.write || acc_err) ? '0 : mem_rdata;
      err_d   = acc_err;
    end
  end

  assign mem_we = access & acc_req.write & ~acc_err;

  // Control and response registers; memory contents are deliberately not reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  mips_dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .wr_en (mem_we),
    .idx   (acc_req.addr[AW+1:2]),
    .wdata (acc_req.wdata),
    .be    (acc_req.be),
    .rdata (mem_rdata)
  );

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Bench for mips_dmem_responder: a WAIT_STATES=2 instance for most tests and
// a WAIT_STATES=0 instance for the zero-wait timing checks. Expected data
// comes from a word-array model updated byte by byte.
module tb_mips_dmem_responder;
  import mips_mem_pkg::*;

  localparam int DEPTH = 256;
  localparam int WS    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // main instance (WAIT_STATES=2)
  logic        req_valid, req_write, req_ready, rsp_valid, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;
  dmem_state_t dbg_state;

  // zero-wait instance
  logic        z_valid, z_write, z_ready, z_rsp_valid, z_err;
  logic [31:0] z_addr, z_wdata, z_rdata;
  logic [3:0]  z_be;
  dmem_state_t z_dbg_state;

  mips_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  mips_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(z_valid), .req_write(z_write),
    .req_addr(z_addr), .req_wdata(z_wdata), .req_be(z_be),
    .req_ready(z_ready), .rsp_valid(z_rsp_valid), .rsp_rdata(z_rdata),
    .rsp_err(z_err), .dbg_state(z_dbg_state)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- reference model ----------------
  logic [31:0] model_mem [DEPTH];
  bit          known [DEPTH];

  function automatic int widx(input logic [31:0] addr);
    return int'((addr >> 2) % DEPTH);
  endfunction

  function automatic bit model_err(input logic [31:0] addr, input logic [3:0] be);
`ifdef MIPS_DMEM_ALIGN_CHECK_EN
    int lo;
    lo = int'(addr % 4);
    if (be == 4'b1111) return (lo != 0);
    if ($countones(be) == 1) return (be != (4'b0001 << lo));
    if (be == 4'b0011 || be == 4'b1100) return (lo % 2 != 0);
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_store(input logic [31:0] addr, input logic [31:0] wdata,
                                      input logic [3:0] be);
    int w;
    w = widx(addr);
    for (int b = 0; b < 4; b++)
      if (be[b]) model_mem[w][8*b +: 8] = wdata[8*b +: 8];
    if (be == 4'b1111) known[w] = 1'b1;
  endfunction

  // ---------------- driver ----------------
  // Presents one request on the main instance, scrambles the inputs after
  // acceptance and returns what the response looked like. lat=0 on timeout.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output logic err,
                        output int lat, output logic acc_ok, output int ready_bad);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    acc_ok = req_ready;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_be = 4'($urandom);
    lat = 0; rdata = '0; err = 1'b0; ready_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (req_ready) ready_bad++;
      if (rsp_valid) begin
        lat = k; rdata = rsp_rdata; err = rsp_err;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    tests_run++; if (rsp_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata); end
    tests_run++; if (rsp_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", rsp_err); end
    tests_run++; if (z_ready !== 1'b1 || z_rsp_valid !== 1'b0 || z_rdata !== 32'h0) begin
      tests_failed++; $display("FAIL reset_ws0: ready %b valid %b rdata %h expected 1 0 0", z_ready, z_rsp_valid, z_rdata);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er, ok; int lat, rb;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, rd, er, lat, ok, rb);
    model_store(32'h10, 32'hDEADBEEF, 4'b1111);
    tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL st_accept_ready: got %b expected 1", ok); end
    tests_run++; if (lat != WS + 1) begin tests_failed++; $display("FAIL st_latency: got %0d expected %0d", lat, WS + 1); end
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL st_rdata: got %h expected 0", rd); end
    tests_run++; if (rb != 0) begin tests_failed++; $display("FAIL st_ready_busy: got %0d ready cycles expected 0", rb); end
    do_req(1'b0, 32'h10, 32'h0, 4'b1111, rd, er, lat, ok, rb);
    tests_run++; if (lat != WS + 1) begin tests_failed++; $display("FAIL ld_latency: got %0d expected %0d", lat, WS + 1); end
    tests_run++; if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL ld_rdata: got %h expected deadbeef", rd); end
    // response data holds after the pulse
    @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL ld_hold: valid %b rdata %h expected 0 deadbeef", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_partial();
    logic [31:0] rd; logic er, ok; int lat, rb;
    do_req(1'b1, 32'h20, 32'h11223344, 4'b1111, rd, er, lat, ok, rb);
    model_store(32'h20, 32'h11223344, 4'b1111);
    do_req(1'b1, 32'h22, 32'hAABBCCDD, 4'b0100, rd, er, lat, ok, rb);
    model_store(32'h22, 32'hAABBCCDD, 4'b0100);
    do_req(1'b0, 32'h20, 32'h0, 4'b1111, rd, er, lat, ok, rb);
    tests_run++; if (rd !== 32'h11BB3344) begin tests_failed++; $display("FAIL partial_merge: got %h expected 11bb3344", rd); end
    tests_run++; if (rd !== model_mem[widx(32'h20)]) begin tests_failed++; $display("FAIL partial_model: got %h expected %h", rd, model_mem[widx(32'h20)]); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic er, ok; int lat, rb;
    do_req(1'b1, 32'h400, 32'h5A5A5A5A, 4'b1111, rd, er, lat, ok, rb);
    model_store(32'h400, 32'h5A5A5A5A, 4'b1111);
    do_req(1'b0, 32'h0, 32'h0, 4'b1111, rd, er, lat, ok, rb);
    tests_run++; if (rd !== 32'h5A5A5A5A) begin tests_failed++; $display("FAIL wrap_rdata: got %h expected 5a5a5a5a", rd); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) begin
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'b1111;
      end
      tests_run++; if (req_ready !== ((i % 4) == 0)) begin tests_failed++; $display("FAIL b2b_ready[%0d]: got %b expected %b", i, req_ready, (i % 4) == 0); end
      tests_run++; if (rsp_valid !== ((i % 4) == 3)) begin tests_failed++; $display("FAIL b2b_rsp[%0d]: got %b expected %b", i, rsp_valid, (i % 4) == 3); end
      if ((i % 4) == 3) begin
        tests_run++; if (rsp_rdata !== model_mem[widx(32'h10)]) begin tests_failed++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", i, rsp_rdata, model_mem[widx(32'h10)]); end
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_ws0();
    @(negedge clk);
    z_valid = 1'b1; z_write = 1'b1; z_addr = 32'h8; z_wdata = 32'h12345678; z_be = 4'b1111;
    @(posedge clk);
    #1 z_valid = 1'b0; z_write = 1'b0; z_wdata = $urandom;
    @(negedge clk);
    tests_run++; if (z_rsp_valid !== 1'b1 || z_ready !== 1'b0) begin
      tests_failed++; $display("FAIL ws0_latency: rsp %b ready %b expected 1 0", z_rsp_valid, z_ready);
    end
    tests_run++; if (z_rdata !== 32'h0) begin tests_failed++; $display("FAIL ws0_store_rdata: got %h expected 0", z_rdata); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin z_valid = 1'b1; z_write = 1'b0; z_addr = 32'h8; end
      tests_run++; if (z_ready !== ((i % 2) == 0)) begin tests_failed++; $display("FAIL ws0_ready[%0d]: got %b expected %b", i, z_ready, (i % 2) == 0); end
      tests_run++; if (z_rsp_valid !== ((i % 2) == 1)) begin tests_failed++; $display("FAIL ws0_rsp[%0d]: got %b expected %b", i, z_rsp_valid, (i % 2) == 1); end
      if ((i % 2) == 1) begin
        tests_run++; if (z_rdata !== 32'h12345678) begin tests_failed++; $display("FAIL ws0_rdata[%0d]: got %h expected 12345678", i, z_rdata); end
      end
    end
    @(negedge clk);
    z_valid = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic er, ok; int lat, rb;
    do_req(1'b1, 32'h30, 32'h0BADF00D, 4'b1111, rd, er, lat, ok, rb);
    model_store(32'h30, 32'h0BADF00D, 4'b1111);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'hFFFFFFFF; req_be = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
      tests_failed++; $display("FAIL midrst_state: ready %b valid %b rdata %h expected 1 0 0", req_ready, rsp_valid, rsp_rdata);
    end
    do_req(1'b0, 32'h30, 32'h0, 4'b1111, rd, er, lat, ok, rb);
    tests_run++; if (rd !== 32'h0BADF00D) begin tests_failed++; $display("FAIL midrst_abandon: got %h expected 0badf00d", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic er, ok; int lat, rb;
    logic exp_e;
    exp_e = model_err(32'h31, 4'b1111);
    do_req(1'b1, 32'h31, 32'hCAFEF00D, 4'b1111, rd, er, lat, ok, rb);
    if (!exp_e) model_store(32'h31, 32'hCAFEF00D, 4'b1111);
    tests_run++; if (er !== exp_e) begin tests_failed++; $display("FAIL misalign_err: got %b expected %b", er, exp_e); end
    tests_run++; if (lat != WS + 1) begin tests_failed++; $display("FAIL misalign_latency: got %0d expected %0d", lat, WS + 1); end
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL misalign_rdata: got %h expected 0", rd); end
    do_req(1'b0, 32'h30, 32'h0, 4'b1111, rd, er, lat, ok, rb);
    tests_run++; if (rd !== model_mem[widx(32'h30)]) begin tests_failed++; $display("FAIL misalign_word: got %h expected %h", rd, model_mem[widx(32'h30)]); end
    tests_run++; if (er !== 1'b0) begin tests_failed++; $display("FAIL misalign_load_err: got %b expected 0", er); end
  endtask

  task automatic test_random();
    logic [31:0] rd, addr, wdata; logic er, ok, wr, exp_e; int lat, rb, w;
    logic [3:0] be;
    for (int i = 0; i < 16; i++) begin
      wdata = $urandom;
      do_req(1'b1, 32'(i * 4), wdata, 4'b1111, rd, er, lat, ok, rb);
      model_store(32'(i * 4), wdata, 4'b1111);
    end
    for (int n = 0; n < 120; n++) begin
      addr  = ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
      wr    = 1'($urandom);
      wdata = $urandom;
      be    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
      if ($urandom_range(0, 3) == 0) addr[1:0] = 2'b00;
      exp_e = model_err(addr, be);
      w     = widx(addr);
      do_req(wr, addr, wdata, be, rd, er, lat, ok, rb);
      tests_run++; if (lat != WS + 1 || ok !== 1'b1 || rb != 0) begin
        tests_failed++; $display("FAIL rnd_timing[%0d]: lat %0d ready %b busy %0d expected %0d 1 0", n, lat, ok, rb, WS + 1);
      end
      tests_run++; if (er !== exp_e) begin tests_failed++; $display("FAIL rnd_err[%0d]: got %b expected %b", n, er, exp_e); end
      if (exp_e || wr) begin
        tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL rnd_wr_rdata[%0d]: got %h expected 0", n, rd); end
        if (!exp_e) model_store(addr, wdata, be);
      end else if (known[w]) begin
        tests_run++; if (rd !== model_mem[w]) begin tests_failed++; $display("FAIL rnd_rdata[%0d]: addr %h got %h expected %h", n, addr, rd, model_mem[w]); end
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    z_valid = 1'b0; z_write = 1'b0; z_addr = '0; z_wdata = '0; z_be = '0;
    for (int i = 0; i < DEPTH; i++) begin model_mem[i] = '0; known[i] = 1'b0; end
    test_reset();
    test_store_load();
    test_partial();
    test_wrap();
    test_back_to_back();
    test_ws0();
    test_reset_mid_wait();
    test_misaligned();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
